// File: rtl/ann_pkg.sv
// ----------------------------------------------------------------------------
// ann_pkg
// Shared constants for the neuron weight path: weight word width, number of
// weights per neuron, weight BRAM address width, and the state encoding of
// the weight fetch controller.
// ----------------------------------------------------------------------------
package ann_pkg;

    localparam int WEIGHT_W = 16;  // weight word width
    localparam int N_INPUTS = 28;  // weights per neuron
    localparam int WADDR_W  = 5;   // weight BRAM address width

    // Fetch controller states, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // BUSY covers the pass itself, not the closing DONE cycle.
    function automatic logic is_busy(input logic [1:0] st);
        return (st != ST_IDLE) && (st != ST_FINISH);
    endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// ----------------------------------------------------------------------------
// weight_skid_fifo
// Two-entry synchronous FIFO that decouples BRAM read returns from the
// consumer handshake. Payload is {last, data}. A push and a pop in the same
// cycle are both honoured, even when the FIFO is full.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_i        write push_data_i at the tail
//   push_data_i   {last, data} payload
//   pop_i         drop the head entry (ignored when empty)
//   head_o        current head entry (valid when count_o != 0)
//   count_o       number of stored entries, 0..2
// ----------------------------------------------------------------------------
module weight_skid_fifo
    import ann_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W:0]   push_data_i,
    input  logic              pop_i,
    output logic [DATA_W:0]   head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    // A full FIFO can still accept a word if the head leaves in the same cycle.
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    // NOTE: the two storage entries are reset as well, so the stream data
    // output reads 0 right after reset instead of whatever was left behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// weight_fetch_ctrl
// Read-side initiator for one weight BRAM. On START it reads addresses
// 0..DEPTH-1 once each and streams the words out through a 2-entry skid FIFO
// as a valid/ready stream; the word from address DEPTH-1 carries W_LAST.
// The BRAM latches EN/ADDR on the falling edge, so a read issued on one
// rising edge has its data ready on the next: latency is exactly one cycle.
//
// Ports:
//   CLK, RESETN   clock, asynchronous active-low reset
//   START         one-cycle pulse, starts a pass when idle
//   BUSY          pass in progress
//   DONE          one-cycle pulse after the last word has been handshaken
//   BRAM_ADDR     BRAM read address
//   BRAM_EN       BRAM read strobe
//   BRAM_WE       BRAM write enable, always 0
//   BRAM_DO       BRAM read data
//   W_DATA        stream data
//   W_VALID       stream valid
//   W_READY       stream ready from the consumer
//   W_LAST        marks the final weight of the pass
// ----------------------------------------------------------------------------
module weight_fetch_ctrl
    import ann_pkg::*;
#(
    parameter int DEPTH  = N_INPUTS,
    parameter int ADDR_W = WADDR_W,
    parameter int DATA_W = WEIGHT_W
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_DATA,
    output logic              W_VALID,
    input  logic              W_READY,
    output logic              W_LAST
);

    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              inflight_q;       // read issued last edge, data due next edge
    logic              inflight_last_q;  // that read targets address DEPTH-1

    logic              issue;
    logic              pop;
    logic [2:0]        fill;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;

    assign W_VALID = (fifo_count != 2'd0);
    assign pop     = W_VALID && W_READY;

    // Credit check: entries held plus the read in flight, minus the word
    // leaving this cycle, must leave room for one more word.
    assign fill  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == ST_FETCH) && (issued_q < DEPTH_C) && (fill < 3'd2);

    // NOTE: every next-state signal takes its hold value first, so no branch
    // of the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        addr_d   = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_FETCH;
                    issued_d = '0;
                    addr_d   = '0;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    // BRAM_ADDR shows the address being read; it stops at DEPTH-1.
                    issued_d = issued_q + 1'b1;
                    addr_d   = issued_q[ADDR_W-1:0];
                end
                if (issued_q == DEPTH_C) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The LAST word leaving as the only stored word means nothing remains.
                if (pop && W_LAST && (fifo_count == 2'd1) && !inflight_q) begin
                    state_d = ST_FINISH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q         <= ST_IDLE;
            issued_q        <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            addr_q          <= addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (issued_q == LAST_C);
        end
    end

    weight_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RESETN),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, BRAM_DO}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign BRAM_ADDR = addr_q;
    assign BRAM_EN   = inflight_q;
    assign BRAM_WE   = 1'b0;
    assign W_DATA    = fifo_head[DATA_W-1:0];
    // Stale head contents must not show a LAST flag while nothing is valid.
    assign W_LAST    = fifo_head[DATA_W] && W_VALID;
    assign BUSY      = is_busy(state_q);
    assign DONE      = (state_q == ST_FINISH);

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Read-side initiator for a single weight BRAM, i.e. a 28x16 weight memory with a negedge-registered read port.
- On START, it walks BRAM addresses 0..DEPTH-1 and issues one read per address.
- Returned words go into a 2-entry skid FIFO and leave as a valid/ready stream with a LAST flag, feeding the neuron MAC datapath.
- It never writes the BRAM: WE is held at 0 at all times.

Parameters:
- DEPTH, 28, number of weights per neuron (addresses 0..DEPTH-1)
- ADDR_W, 5, BRAM address width; must satisfy 2^ADDR_W >= DEPTH
- DATA_W, 16, weight word width

Ports:
- CLK  in  1  system clock; all controller logic on posedge
- RESETN  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; begins a pass; ignored unless state is IDLE
- BUSY  out  1  high from the cycle after an accepted START until DONE is asserted
- DONE  out  1  one-cycle pulse after the last word has been handshaken
- BRAM_ADDR  out  ADDR_W  BRAM address
- BRAM_EN  out  1  BRAM enable (read strobe)
- BRAM_WE  out  1  constant 0
- BRAM_DO  in  DATA_W  BRAM read data
- W_DATA  out  DATA_W  stream data (FIFO head)
- W_VALID  out  1  FIFO non-empty
- W_READY  in  1  consumer ready
- W_LAST  out  1  high with the word read from address DEPTH-1

Behaviour:
- Reset (async, RESETN=0):
  - state=IDLE; BUSY=0, DONE=0, BRAM_EN=0, BRAM_ADDR=0, W_VALID=0, W_DATA=0, W_LAST=0.
  - FIFO emptied, in-flight flag cleared, address and word counters cleared.
  - Reset mid-pass abandons the pass; no DONE is produced.
- Read timing:
  - BRAM_EN/BRAM_ADDR are registered on posedge t.
  - The BRAM captures them at the negedge inside cycle t.
  - BRAM_DO is sampled at posedge t+1 and written into the FIFO.
  - Read latency is therefore exactly 1 cycle. An in-flight flag records an issued read and is set for that one cycle.
- Issue rule (FETCH state only): a read is issued when issued_cnt < DEPTH and (fifo_count + inflight - pop) < 2, where pop = W_VALID & W_READY in the same cycle.
  - This guarantees the FIFO never overflows under any W_READY pattern.
  - With W_READY held high, one word per cycle is sustained.
- Handshake:
  - A word transfers when W_VALID & W_READY.
  - W_DATA and W_LAST are stable while W_VALID=1 and W_READY=0.
  - W_VALID never drops without a transfer.
  - Simultaneous push and pop on a full or one-entry FIFO keeps the count unchanged and preserves order.
- State machine:
  - IDLE -> FETCH on START (BRAM_ADDR=0, counters cleared).
  - FETCH -> DRAIN once DEPTH reads have been issued.
  - DRAIN -> FINISH once the word with W_LAST is handshaken and the FIFO and in-flight flag are both empty.
  - FINISH asserts DONE for 1 cycle and then returns to IDLE.
- BUSY = (state != IDLE) & (state != FINISH).
- START during FETCH, DRAIN or FINISH is ignored. START in the same cycle as DONE is also ignored; the next pass needs START in IDLE.
- Address increments after each issue. It stops at DEPTH-1 and does not wrap; it resets to 0 on the next START.
- BRAM_EN is low in all cycles with no issue.
- W_LAST is stored per FIFO entry. It is set for the word whose read address was DEPTH-1.

Decomposition:
- Shared package (ann_pkg):
  - WEIGHT_W=16, N_INPUTS=28, WADDR_W=5
  - state encoding IDLE/FETCH/DRAIN/FINISH
- One sub-module: weight_skid_fifo, a 2-entry synchronous FIFO with DATA_W+1 payload (data + last), count output, and async active-low reset. The controller owns the issue/credit logic.

Test Plan:
- Setup for all scenarios: BRAM model preloaded with word[i]=16'h0100+i.
- Free-flow: W_READY=1, START pulse -> first W_VALID 2 cycles after START; 28 consecutive words 0x0100..0x011B with no gaps; W_LAST only on 0x011B; DONE 1 cycle after that transfer; BUSY low afterwards.
- Backpressure: W_READY=0 for cycles 3..10 after START -> at most 2 reads issued beyond the words consumed; no word lost or duplicated; W_DATA held at 0x0100 while stalled; full 0x0100..0x011B order preserved.
- Random W_READY (50%, 1000 seeds) -> scoreboard gets the exact sequence and exactly one W_LAST; FIFO count never exceeds 2; BRAM_WE is never 1.
- START re-pulsed during FETCH at word 10 -> ignored; still 28 words; single DONE.
- RESETN low at word 15 -> all outputs 0 immediately (async); no DONE; a new START afterwards yields 0x0100 first.
- Back-to-back passes: START in the cycle after DONE -> second pass identical to the first (28 words starting at 0x0100).
